mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 datapath multiplexer (source selects a/b/c/d) between four requesters.
- Produces a registered 2-bit select for the mux and a one-hot grant back to the requesters.
- Holds a grant until the consumer signals transaction completion, or until a hold-timeout forces rotation.
- Sits between the requesting stages (e.g. debug unit, pipeline sources) and the shared mux/consumer.

---
 rtl/mux4_rr_arbiter_pkg.sv | 17 +
 rtl/mux4_rr_arbiter_pick.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 104 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter: requester count,
// select width, FSM state encoding and a one-hot helper.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational rotate-priority encoder: returns the first set bit of eff
// scanning ptr, ptr+1, ... with wrap-around.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] eff,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (eff[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux. A grant is held
// until i_done, an abort (request dropped or masked) or the hold timeout.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic               i_done,
  output logic [SEL_W-1:0]   o_sel,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_busy,
  output logic               o_abort,
  output logic               o_timeout
);

  localparam int                CNT_W      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic              TIMEOUT_EN = (MAX_HOLD != 0);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_REQ-1:0] eff;
  logic               in_grant;
  logic               rel_done;
  logic               rel_abort;
  logic               rel_timeout;
  logic               rel_any;
  logic [SEL_W-1:0]   pick_ptr;
  logic               found;
  logic [SEL_W-1:0]   idx;

  // Release causes are mutually exclusive by construction: done > abort > timeout.
  always_comb begin
    eff         = i_req & i_mask;
    in_grant    = (state == GRANT);
    rel_done    = in_grant && i_done;
    rel_abort   = in_grant && !i_done && !eff[o_sel];
    rel_timeout = in_grant && !i_done && eff[o_sel] && TIMEOUT_EN && (cnt == HOLD_LAST);
    rel_any     = rel_done || rel_abort || rel_timeout;
    pick_ptr    = in_grant ? (o_sel + 1'b1) : ptr;
  end

  // On release the encoder already sees the rotated pointer, so the next
  // winner is granted in the same edge and the old owner ranks last.
  rr_pick4 u_pick (
    .eff   (eff),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (idx)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      o_sel     <= '0;
      o_gnt     <= '0;
      o_busy    <= 1'b0;
      o_abort   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_abort   <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state  <= GRANT;
            o_sel  <= idx;
            o_gnt  <= onehot(idx);
            o_busy <= 1'b1;
            cnt    <= '0;
          end
        end
        GRANT: begin
          if (rel_any) begin
            ptr       <= o_sel + 1'b1;
            o_abort   <= rel_abort;
            o_timeout <= rel_timeout;
            cnt       <= '0;
            if (found) begin
              o_sel <= idx;
              o_gnt <= onehot(idx);
            end else begin
              state  <= IDLE;
              o_gnt  <= '0;
              o_busy <= 1'b0;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a MAX_HOLD=4 instance for the main
// scenarios and a MAX_HOLD=0 instance for the disabled-timeout case.
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       abort;
    logic       timeout;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_req;
  logic [3:0] i_mask;
  logic       i_done;

  logic [1:0] sel, nh_sel;
  logic [3:0] gnt, nh_gnt;
  logic       busy, nh_busy;
  logic       abort_p, nh_abort;
  logic       timeout_p, nh_timeout;

  exp_t sb[$];
  exp_t e;
  exp_t obs;
  int   compared   = 0;
  int   mismatched = 0;

  always #5 i_clk = ~i_clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_mask    (i_mask),
    .i_done    (i_done),
    .o_sel     (sel),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_abort   (abort_p),
    .o_timeout (timeout_p)
  );

  mux4_rr_arbiter #(.MAX_HOLD(0)) dut_nohold (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_mask    (i_mask),
    .i_done    (i_done),
    .o_sel     (nh_sel),
    .o_gnt     (nh_gnt),
    .o_busy    (nh_busy),
    .o_abort   (nh_abort),
    .o_timeout (nh_timeout)
  );

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic a, input logic t);
    exp_t r;
    r.gnt = g; r.sel = s; r.busy = b; r.abort = a; r.timeout = t;
    return r;
  endfunction

  task automatic step(input logic [3:0] req, input logic [3:0] mask, input logic done);
    i_req  = req;
    i_mask = mask;
    i_done = done;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = 4'h0;
    i_mask  = 4'hF;
    i_done  = 1'b0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] req_t [4];
    logic       done_t [4];
    exp_t       exp_t_tab [4];
    i_reset = 1'b1;
    i_req   = 4'h0;
    i_mask  = 4'hF;
    i_done  = 1'b0;
    @(posedge i_clk);
    #1;
    sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
    e = sb.pop_front();
    obs = {gnt, sel, busy, abort_p, timeout_p};
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("[TB] FAIL reset_hold: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
               obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
    end
    i_reset = 1'b0;
    req_t  = '{4'b0010, 4'b1000, 4'b1010, 4'b0010};
    done_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_t_tab = '{mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0), mk(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0),
                  mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0), mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0)};
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        // mid-grant asynchronous reset, away from the clock edge
        #3 i_reset = 1'b1;
        #1;
        sb.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0));
        e = sb.pop_front();
        obs = {gnt, sel, busy, abort_p, timeout_p};
        compared++;
        if (obs !== e) begin
          mismatched++;
          $display("[TB] FAIL reset_async: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                   obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
        end
        #1 i_reset = 1'b0;
      end
      sb.push_back(exp_t_tab[k]);
      step(req_t[k], 4'hF, done_t[k]);
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL reset_seq[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      int w;
      w = ((k - 1) / 3) % 4;
      sb.push_back(mk(4'b0001 << w, w[1:0], 1'b1, 1'b0, 1'b0));
      step(4'hF, 4'hF, (k % 3 == 1) && (k > 1));
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL round_robin[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] req_t  [6];
    logic [3:0] mask_t [6];
    logic       done_t [6];
    exp_t       exp_t_tab [6];
    do_reset();
    req_t  = '{4'b0100, 4'b0101, 4'b0101, 4'b0000, 4'b0100, 4'b0100};
    mask_t = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b1011, 4'b1011};
    done_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_t_tab = '{mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0), mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0),
                  mk(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0), mk(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0),
                  mk(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0), mk(4'b0000, 2'd2, 1'b0, 1'b0, 1'b0)};
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_t_tab[k]);
      step(req_t[k], mask_t[k], done_t[k]);
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL wrap_skip[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] req_t  [6];
    logic [3:0] mask_t [6];
    exp_t       exp_t_tab [6];
    do_reset();
    req_t  = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    mask_t = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b0111, 4'hF};
    exp_t_tab = '{mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0), mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0),
                  mk(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0), mk(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0),
                  mk(4'b0000, 2'd3, 1'b0, 1'b1, 1'b0), mk(4'b0000, 2'd3, 1'b0, 1'b0, 1'b0)};
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_t_tab[k]);
      step(req_t[k], mask_t[k], 1'b0);
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL abort[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, (k == 5) || (k == 9)));
      step(4'b0001, 4'hF, 1'b0);
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL timeout[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_coincidence();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      if (k >= 5) sb.push_back(mk(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0));
      else        sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
      step(4'b0011, 4'hF, (k == 5));
      e = sb.pop_front();
      obs = {gnt, sel, busy, abort_p, timeout_p};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL coincidence[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  task automatic test_no_timeout();
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      sb.push_back(mk(4'b0001, 2'd0, 1'b1, 1'b0, 1'b0));
      step(4'b0001, 4'hF, 1'b0);
      e = sb.pop_front();
      obs = {nh_gnt, nh_sel, nh_busy, nh_abort, nh_timeout};
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("[TB] FAIL no_timeout[%0d]: got %b/%0d/%b/%b/%b, expected gnt/sel/busy/abort/timeout %b/%0d/%b/%b/%b",
                 k, obs.gnt, obs.sel, obs.busy, obs.abort, obs.timeout, e.gnt, e.sel, e.busy, e.abort, e.timeout);
      end
    end
  endtask

  initial begin
    $display("[TB] starting mux4_rr_arbiter bench");
    test_reset();
    test_round_robin();
    test_wrap_skip();
    test_abort();
    test_timeout();
    test_coincidence();
    test_no_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
